// File: rtl/instr_fetch_queue_pkg.sv
// Shared types for the instruction fetch front-end (FETCHQ_BYPASS_EN selects
// the empty-queue bypass in instr_fetch_queue).
package instr_fetch_queue_pkg;

  localparam int FQ_PC_W  = 9;
  localparam int FQ_INS_W = 32;
  localparam int FQ_DEPTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } FetchState;

  typedef struct packed {
    logic [FQ_PC_W-1:0]  PC;
    logic [FQ_INS_W-1:0] Instr;
  } FetchEntry;

endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// FetchFifo: prefetch storage with head/tail pointers and occupancy count.
// Async clear on rst, synchronous flush on redirect.
module FetchFifo
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int W     = FQ_PC_W + FQ_INS_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = push_data;
        tail_d        = tail_q + AW'(1);
      end
      if (pop) head_d = head_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_data = mem_q[head_q];
  assign count     = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front-end: PC sequencing, credit-based imem requests and redirect
// flush in front of FetchFifo. `FETCHQ_BYPASS_EN adds the empty-queue bypass.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int PC_W  = FQ_PC_W,
  parameter int INS_W = FQ_INS_W,
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Redirect,
  input  logic [PC_W-1:0]        RedirectPC,
  input  logic                   Stall,
  output logic                   IMemReq,
  output logic [PC_W-1:0]        IMemAddr,
  input  logic [INS_W-1:0]       IMemData,
  output logic                   InstrValid,
  output logic [INS_W-1:0]       InstrOut,
  output logic [PC_W-1:0]        InstrPC,
  output logic [$clog2(DEPTH):0] QCount
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [PC_W-1:0]  PC;
    logic [INS_W-1:0] Instr;
  } entry_t;

  FetchState       state_q;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] infl_pc_q, infl_pc_d;
  logic            infl_q, infl_d;
  logic            req, push_rsp, fifo_push, fifo_pop, fifo_vld;
  entry_t          rsp, head;
  logic [CW-1:0]   count;
  logic            unused_rpc_lsb;

  assign unused_rpc_lsb = ^RedirectPC[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 state_q <= IDLE;
    else if (state_q == IDLE) state_q <= RUN;
  end

  // One credit per free entry, counting the response still in flight.
  always_comb begin
    req        = (state_q == RUN) && !Redirect && ((count + CW'(infl_q)) < CW'(DEPTH));
    fetch_pc_d = fetch_pc_q;
    infl_d     = 1'b0;
    infl_pc_d  = infl_pc_q;
    if (Redirect) begin
      fetch_pc_d = {RedirectPC[PC_W-1:2], 2'b00};
    end else if (req) begin
      fetch_pc_d = fetch_pc_q + PC_W'(4);
      infl_d     = 1'b1;
      infl_pc_d  = fetch_pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= '0;
      infl_q     <= 1'b0;
      infl_pc_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      infl_q     <= infl_d;
      infl_pc_q  <= infl_pc_d;
    end
  end

  assign rsp      = '{PC: infl_pc_q, Instr: IMemData};
  assign push_rsp = infl_q && !Redirect;
  assign fifo_vld = (count != '0);
  assign fifo_pop = fifo_vld && !Stall && !Redirect;

`ifdef FETCHQ_BYPASS_EN
  logic byp;
  // An arriving response with an empty queue goes straight to decode.
  always_comb begin
    byp        = push_rsp && !fifo_vld;
    fifo_push  = push_rsp && !(byp && !Stall);
    InstrValid = fifo_vld || byp;
    InstrOut   = byp ? rsp.Instr : head.Instr;
    InstrPC    = byp ? rsp.PC    : head.PC;
  end
`else
  always_comb begin
    fifo_push  = push_rsp;
    InstrValid = fifo_vld;
    InstrOut   = head.Instr;
    InstrPC    = head.PC;
  end
`endif

  FetchFifo #(.DEPTH(DEPTH), .W(PC_W + INS_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (Redirect),
    .push      (fifo_push),
    .push_data (rsp),
    .pop       (fifo_pop),
    .head_data (head),
    .count     (count)
  );

  assign IMemReq  = req;
  assign IMemAddr = fetch_pc_q;
  assign QCount   = count;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: fetch-side vector table, directed corner
// sequences and random stall/redirect traffic against a queue-level model.
module tb_instr_fetch_queue;
  import instr_fetch_queue_pkg::*;

`ifdef FETCHQ_BYPASS_EN
  localparam bit BYP = 1'b1;
  localparam int LAT = 1;
`else
  localparam bit BYP = 1'b0;
  localparam int LAT = 2;
`endif
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        Redirect;
  logic [8:0]  RedirectPC;
  logic        Stall;
  logic        IMemReq;
  logic [8:0]  IMemAddr;
  logic [31:0] IMemData;
  logic        InstrValid;
  logic [31:0] InstrOut;
  logic [8:0]  InstrPC;
  logic [2:0]  QCount;

  instr_fetch_queue dut (
    .clk(clk), .rst(rst), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .Stall(Stall), .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemData(IMemData),
    .InstrValid(InstrValid), .InstrOut(InstrOut), .InstrPC(InstrPC), .QCount(QCount)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins_of(input logic [8:0] pc);
    return {7'h2A, pc, 7'h13, pc};
  endfunction

  // Synchronous-read instruction memory
  always @(posedge clk) IMemData <= IMemReq ? ins_of(IMemAddr) : 32'hBAD0_BAD0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: fetch PC, one in-flight slot, queue of entries
  bit          m_run;
  logic [8:0]  m_fpc, m_ipc;
  bit          m_infl;
  FetchEntry   q[$];

  task automatic model_reset();
    m_run = 0; m_fpc = '0; m_ipc = '0; m_infl = 0; q.delete();
  endtask

  task automatic model_step(input logic rd, input logic [8:0] rp, input logic st);
    int   n;
    bit   push, byp, vld, req, consumed;
    logic [8:0] epc;
    n        = q.size();
    push     = m_infl && !rd;
    byp      = BYP && push && (n == 0);
    vld      = (n > 0) || byp;
    req      = m_run && !rd && ((n + int'(m_infl)) < DEPTH);
    consumed = 0;
    check("req",   IMemReq,    req);
    check("addr",  IMemAddr,   m_fpc);
    check("count", QCount,     n);
    check("valid", InstrValid, vld);
    if (vld) begin
      epc = (n > 0) ? q[0].PC : m_ipc;
      check("pc",    InstrPC,  epc);
      check("instr", InstrOut, ins_of(epc));
    end
    if (rd) begin
      q.delete();
      m_infl = 0;
      m_fpc  = {rp[8:2], 2'b00};
    end else begin
      if (vld && !st) begin
        if (n > 0) void'(q.pop_front());
        else       consumed = 1;
      end
      if (push && !consumed) q.push_back('{PC: m_ipc, Instr: ins_of(m_ipc)});
      m_infl = req;
      if (req) begin
        m_ipc = m_fpc;
        m_fpc = m_fpc + 9'd4;
      end
    end
    m_run = 1;
  endtask

  logic       s_valid, s_req;
  logic [8:0] s_pc, s_addr;
  logic [2:0] s_cnt;

  // Called at a falling edge; samples one cycle and returns at the next falling edge.
  task automatic step(input logic rd, input logic [8:0] rp, input logic st);
    Redirect = rd; RedirectPC = rp; Stall = st;
    #1;
    s_valid = InstrValid; s_req = IMemReq; s_pc = InstrPC; s_addr = IMemAddr; s_cnt = QCount;
    model_step(rd, rp, st);
    @(negedge clk);
  endtask

  typedef struct {
    logic       rd;
    logic [8:0] rpc;
    logic       st;
    logic       exp_req;
    logic [8:0] exp_addr;
  } vec_t;
  vec_t vecs[11];

  initial begin
    int         found, lat;
    logic [8:0] frozen;

    vecs[0]  = '{1'b0, 9'h000, 1'b0, 1'b0, 9'h000};
    vecs[1]  = '{1'b0, 9'h000, 1'b0, 1'b1, 9'h000};
    vecs[2]  = '{1'b0, 9'h000, 1'b0, 1'b1, 9'h004};
    vecs[3]  = '{1'b0, 9'h000, 1'b0, 1'b1, 9'h008};
    vecs[4]  = '{1'b0, 9'h000, 1'b0, 1'b1, 9'h00C};
    vecs[5]  = '{1'b0, 9'h000, 1'b0, 1'b1, 9'h010};
    vecs[6]  = '{1'b1, 9'h1F9, 1'b0, 1'b0, 9'h014};
    vecs[7]  = '{1'b0, 9'h000, 1'b0, 1'b1, 9'h1F8};
    vecs[8]  = '{1'b0, 9'h000, 1'b0, 1'b1, 9'h1FC};
    vecs[9]  = '{1'b0, 9'h000, 1'b0, 1'b1, 9'h000};
    vecs[10] = '{1'b0, 9'h000, 1'b0, 1'b1, 9'h004};

    rst = 1'b1; Redirect = 1'b0; RedirectPC = '0; Stall = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst0_req",   IMemReq,    0);
    check("rst0_addr",  IMemAddr,   0);
    check("rst0_valid", InstrValid, 0);
    check("rst0_instr", InstrOut,   0);
    check("rst0_pc",    InstrPC,    0);
    check("rst0_count", QCount,     0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Startup, redirect near top of memory, address wrap
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].rd, vecs[i].rpc, vecs[i].st);
      check($sformatf("vec%0d_req", i),  s_req,  vecs[i].exp_req);
      check($sformatf("vec%0d_addr", i), s_addr, vecs[i].exp_addr);
    end
    repeat (4) step(1'b0, 9'h0, 1'b0);

    // Long stall: queue fills, fetch stops, head frozen
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 9'h0, 1'b1);
      if (i == 0) frozen = s_pc;
    end
    check("stall_count", s_cnt,   4);
    check("stall_req",   s_req,   0);
    check("stall_valid", s_valid, 1);
    check("stall_pc",    s_pc,    frozen);
    repeat (6) step(1'b0, 9'h0, 1'b0);

    // Redirect with three queued and one in flight
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (q.size() == 3 && m_infl) found = 1;
      else step(1'b0, 9'h0, 1'b1);
    end
    check("redir_setup", found, 1);
    step(1'b1, 9'h040, 1'b0);
    step(1'b0, 9'h0, 1'b0);
    check("redir_flush_valid", s_valid, 0);
    found = 0; lat = 0;
    for (int i = 2; i < 10 && !found; i++) begin
      step(1'b0, 9'h0, 1'b0);
      if (s_valid) begin found = 1; lat = i; end
    end
    check("redir_lat", lat, 1 + LAT);
    check("redir_pc0", s_pc, 9'h040);
    step(1'b0, 9'h0, 1'b0);
    check("redir_pc1", s_pc, 9'h044);

    // Redirect and stall together with a full queue
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (q.size() == DEPTH) found = 1;
      else step(1'b0, 9'h0, 1'b1);
    end
    check("full_setup", found, 1);
    step(1'b1, 9'h100, 1'b1);
    step(1'b0, 9'h0, 1'b0);
    check("flush_count", s_cnt,  0);
    check("flush_req",   s_req,  1);
    check("flush_addr",  s_addr, 9'h100);
    repeat (5) step(1'b0, 9'h0, 1'b0);

    // Asynchronous reset pulse between edges
    Redirect = 1'b0; Stall = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_req",   IMemReq,    0);
    check("arst_addr",  IMemAddr,   0);
    check("arst_valid", InstrValid, 0);
    check("arst_instr", InstrOut,   0);
    check("arst_pc",    InstrPC,    0);
    check("arst_count", QCount,     0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    found = 0; lat = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      step(1'b0, 9'h0, 1'b0);
      if (s_valid) begin found = 1; lat = i; end
    end
    check("arst_lat", lat, 1 + LAT);
    check("arst_first_pc", s_pc, 9'h000);

    // Random stall/redirect traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) == 0), 9'($urandom_range(0, 511)),
           ($urandom_range(0, 2) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
